// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the single-port
// 1024x32 CPU data memory. Port 0 is the load/store unit and port 1 is the
// test/loader port. Every access is one IDLE cycle to accept the request,
// then one BUSY cycle to drive the memory, then a one-cycle response pulse.
module data_mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_writeen,
    output logic [DATA_W-1:0] mem_writeint,
    input  logic [DATA_W-1:0] mem_RD
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state;
    state_t             state_next;

    // last_grant holds the port that won most recently; the other port wins a tie.
    logic               last_grant;
    logic               lat_gid;
    logic               lat_we;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration, next state and memory drive; ready is held low during reset.
    always_comb begin
        state_next   = state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        mem_addr     = '0;
        mem_writeen  = 1'b0;
        mem_writeint = '0;
        case (state)
            IDLE: begin
                req0_ready = !reset && req0_valid && (!req1_valid || last_grant);
                req1_ready = !reset && req1_valid && (!req0_valid || !last_grant);
                if (req0_ready || req1_ready) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                mem_addr     = lat_addr;
                mem_writeen  = lat_we;
                mem_writeint = lat_wdata;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the accepted request and record the winner for round-robin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            lat_gid    <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (req0_ready || req1_ready) begin
            last_grant <= req1_ready;
            lat_gid    <= req1_ready;
            lat_we     <= req1_ready ? req1_we    : req0_we;
            lat_addr   <= req1_ready ? req1_addr  : req0_addr;
            lat_wdata  <= req1_ready ? req1_wdata : req0_wdata;
        end
    end

    // Close the BUSY cycle: pulse the granted port and capture read data on reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp0_rdata <= '0;
            resp1_rdata <= '0;
        end else begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            if (state == BUSY) begin
                if (lat_gid) begin
                    resp1_valid <= 1'b1;
                    if (!lat_we) begin
                        resp1_rdata <= mem_RD;
                    end
                end else begin
                    resp0_valid <= 1'b1;
                    if (!lat_we) begin
                        resp0_rdata <= mem_RD;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_data_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_we, req0_ready, resp0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, resp0_rdata;
    logic          req1_valid, req1_we, req1_ready, resp1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, resp1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_writeen;
    logic [DW-1:0] mem_writeint, mem_RD;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem     [1024];
    logic [DW-1:0] ref_mem [1024];
    logic          mem_init;

    int glog_p[$];
    int glog_t[$];

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
        .mem_addr(mem_addr), .mem_writeen(mem_writeen),
        .mem_writeint(mem_writeint), .mem_RD(mem_RD)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'h1000_0000 + 32'(i) * 32'd7;
    endfunction

    // Single-port memory: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
        end else if (mem_writeen) begin
            mem[mem_addr] <= mem_writeint;
        end
    end
    assign mem_RD = mem[mem_addr];

    function automatic logic rdy(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction
    function automatic logic rv(input int p);
        return (p == 0) ? resp0_valid : resp1_valid;
    endfunction
    function automatic logic [DW-1:0] rd(input int p);
        return (p == 0) ? resp0_rdata : resp1_rdata;
    endfunction

    task automatic drive(input int p, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One isolated access; returns what was observed in the accept, BUSY and response cycles.
    task automatic access(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int waited, output logic acc,
                          output logic rv1, output logic we1, output logic [AW-1:0] a1,
                          output logic [DW-1:0] wd1, output logic rv2, output logic oth2,
                          output logic we2, output logic [DW-1:0] rd2);
        acc = 1'b0; waited = 0; rv1 = 1'b0; we1 = 1'b0; a1 = '0; wd1 = '0;
        rv2 = 1'b0; oth2 = 1'b0; we2 = 1'b0; rd2 = '0;
        @(negedge clk);
        drive(p, 1'b1, we, a, d);
        for (int i = 0; i < 8; i++) begin
            #1;
            if (rdy(p) === 1'b1) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
            waited++;
        end
        if (acc) begin
            @(posedge clk);
            #1 drive(p, 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            rv1 = rv(p); we1 = mem_writeen; a1 = mem_addr; wd1 = mem_writeint;
            @(negedge clk);
            rv2 = rv(p); oth2 = rv(1 - p); we2 = mem_writeen; rd2 = rd(p);
        end else begin
            drive(p, 1'b0, 1'b0, '0, '0);
        end
    endtask

    // Cycle-level reference: rules for ready, response timing, read data and memory drive.
    task automatic run_model(input int n, input bit force_both);
        bit            pend[2];
        logic          pwe[2];
        logic [AW-1:0] pa[2];
        logic [DW-1:0] pd[2];
        int            cnt[2];
        int            due[2];
        logic [DW-1:0] due_data[2];
        logic [DW-1:0] mrd[2];
        int            free_at, last, busy_t, gp;
        logic          busy_we, e0, e1, erv, idle;
        logic [AW-1:0] busy_a;
        logic [DW-1:0] busy_d;
        free_at = 0; last = 1; busy_t = -10; busy_we = 1'b0; busy_a = '0; busy_d = '0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; pwe[p] = 1'b0; pa[p] = '0; pd[p] = '0; cnt[p] = 0;
            due[p] = -10; due_data[p] = '0; mrd[p] = '0;
        end
        glog_p.delete();
        glog_t.delete();
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && !force_both && $urandom_range(0, 9) == 0) pend[p] = 1'b0;
                if (!pend[p] && t < n - 3 && (force_both || $urandom_range(0, 2) == 0)) begin
                    pend[p] = 1'b1;
                    pwe[p]  = force_both ? 1'b0 : 1'($urandom_range(0, 1));
                    if (force_both) pa[p] = 10'(p * 512 + cnt[p]);
                    else pa[p] = ($urandom_range(0, 7) == 0) ? 10'd1023 : 10'($urandom_range(0, 15));
                    pd[p] = $urandom;
                    cnt[p]++;
                end
                drive(p, pend[p], pend[p] ? pwe[p] : 1'b0, pend[p] ? pa[p] : '0, pend[p] ? pd[p] : '0);
            end
            #1;
            idle = (t >= free_at);
            e0 = idle && pend[0] && (!pend[1] || last == 1);
            e1 = idle && pend[1] && (!pend[0] || last == 0);
            n_checks++;
            if (req0_ready !== e0) begin
                n_fail++; $display("FAIL ready0 t=%0d got=%b exp=%b", t, req0_ready, e0);
            end
            n_checks++;
            if (req1_ready !== e1) begin
                n_fail++; $display("FAIL ready1 t=%0d got=%b exp=%b", t, req1_ready, e1);
            end
            for (int p = 0; p < 2; p++) begin
                erv = (due[p] == t);
                if (erv) mrd[p] = due_data[p];
                n_checks++;
                if (rv(p) !== erv) begin
                    n_fail++; $display("FAIL resp%0d_valid t=%0d got=%b exp=%b", p, t, rv(p), erv);
                end
                n_checks++;
                if (rd(p) !== mrd[p]) begin
                    n_fail++; $display("FAIL resp%0d_rdata t=%0d got=%h exp=%h", p, t, rd(p), mrd[p]);
                end
            end
            n_checks++;
            if (t == busy_t) begin
                if (mem_writeen !== busy_we || mem_addr !== busy_a || mem_writeint !== busy_d) begin
                    n_fail++;
                    $display("FAIL mem_busy t=%0d got=%b/%h/%h exp=%b/%h/%h", t, mem_writeen, mem_addr,
                             mem_writeint, busy_we, busy_a, busy_d);
                end
            end else if (mem_writeen !== 1'b0 || mem_addr !== '0 || mem_writeint !== '0) begin
                n_fail++;
                $display("FAIL mem_idle t=%0d got=%b/%h/%h exp=0/0/0", t, mem_writeen, mem_addr, mem_writeint);
            end
            if (e0 || e1) begin
                gp = e1 ? 1 : 0;
                last = gp; free_at = t + 2; busy_t = t + 1;
                busy_we = pwe[gp]; busy_a = pa[gp]; busy_d = pwe[gp] ? pd[gp] : '0;
                if (!pwe[gp]) busy_d = pd[gp];
                due[gp] = t + 2;
                due_data[gp] = pwe[gp] ? mrd[gp] : ref_mem[pa[gp]];
                if (pwe[gp]) ref_mem[pa[gp]] = pd[gp];
                glog_p.push_back(gp);
                glog_t.push_back(t);
                pend[gp] = 1'b0;
            end
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 10'd3, '0);
        drive(1, 1'b1, 1'b0, 10'd4, '0);
        #1;
        n_checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready);
        end
        n_checks++;
        if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || resp0_rdata !== '0 || resp1_rdata !== '0) begin
            n_fail++; $display("FAIL reset_resp got=%b %b %h %h exp=0 0 0 0",
                               resp0_valid, resp1_valid, resp0_rdata, resp1_rdata);
        end
        n_checks++;
        if (mem_writeen !== 1'b0 || mem_addr !== '0 || mem_writeint !== '0) begin
            n_fail++; $display("FAIL reset_mem got=%b/%h/%h exp=0/0/0", mem_writeen, mem_addr, mem_writeint);
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_write_seq();
        logic [AW-1:0] addrs[3] = '{10'd0, 10'd1, 10'd2};
        logic [DW-1:0] datas[3] = '{32'd49, 32'd7, 32'd2};
        int w; logic acc, rv1, we1, rv2, oth2, we2;
        logic [AW-1:0] a1; logic [DW-1:0] wd1, rd2;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            access(0, 1'b1, addrs[i], datas[i], w, acc, rv1, we1, a1, wd1, rv2, oth2, we2, rd2);
            n_checks++;
            if (acc !== 1'b1 || w != 0) begin
                n_fail++; $display("FAIL wr_accept[%0d] got acc=%b wait=%0d exp acc=1 wait=0", i, acc, w);
            end
            n_checks++;
            if (rv1 !== 1'b0 || we1 !== 1'b1 || a1 !== addrs[i] || wd1 !== datas[i]) begin
                n_fail++; $display("FAIL wr_busy[%0d] got rv=%b we=%b a=%h d=%h exp rv=0 we=1 a=%h d=%h",
                                   i, rv1, we1, a1, wd1, addrs[i], datas[i]);
            end
            n_checks++;
            if (rv2 !== 1'b1 || we2 !== 1'b0 || oth2 !== 1'b0 || rd2 !== '0) begin
                n_fail++; $display("FAIL wr_resp[%0d] got rv=%b we=%b other=%b rdata=%h exp rv=1 we=0 other=0 rdata=0",
                                   i, rv2, we2, oth2, rd2);
            end
            ref_mem[addrs[i]] = datas[i];
        end
    endtask

    task automatic test_read_seq();
        logic [DW-1:0] exp_d[3] = '{32'd49, 32'd7, 32'd2};
        int w; logic acc, rv1, we1, rv2, oth2, we2;
        logic [AW-1:0] a1; logic [DW-1:0] wd1, rd2;
        for (int i = 0; i < 3; i++) begin
            access(1, 1'b0, 10'(i), '0, w, acc, rv1, we1, a1, wd1, rv2, oth2, we2, rd2);
            n_checks++;
            if (acc !== 1'b1 || rv1 !== 1'b0 || we1 !== 1'b0 || a1 !== 10'(i)) begin
                n_fail++; $display("FAIL rd_busy[%0d] got acc=%b rv=%b we=%b a=%h exp 1 0 0 %h",
                                   i, acc, rv1, we1, a1, 10'(i));
            end
            n_checks++;
            if (rv2 !== 1'b1 || oth2 !== 1'b0 || rd2 !== exp_d[i]) begin
                n_fail++; $display("FAIL rd_resp[%0d] got rv=%b resp0=%b rdata=%0d exp rv=1 resp0=0 rdata=%0d",
                                   i, rv2, oth2, rd2, exp_d[i]);
            end
        end
    endtask

    task automatic test_contention();
        apply_reset();
        run_model(40, 1'b1);
        n_checks++;
        if (glog_p.size() < 8) begin
            n_fail++; $display("FAIL contention_count got=%0d exp>=8", glog_p.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                n_checks++;
                if (glog_p[j] != j % 2 || glog_t[j] != 2 * j) begin
                    n_fail++; $display("FAIL contention_grant[%0d] got port=%0d t=%0d exp port=%0d t=%0d",
                                       j, glog_p[j], glog_t[j], j % 2, 2 * j);
                end
            end
        end
    endtask

    task automatic test_boundary();
        apply_reset();
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 10'd1023, 32'hDEADBEEF);
        drive(1, 1'b1, 1'b0, 10'd1023, '0);
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL bnd_tie got=%b%b exp=10", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        #1;
        n_checks++;
        if (req1_ready !== 1'b0 || mem_writeen !== 1'b1 || mem_addr !== 10'd1023) begin
            n_fail++; $display("FAIL bnd_busy got rdy1=%b we=%b a=%h exp 0 1 3ff", req1_ready, mem_writeen, mem_addr);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (req1_ready !== 1'b1 || resp0_valid !== 1'b1) begin
            n_fail++; $display("FAIL bnd_second got rdy1=%b resp0=%b exp 1 1", req1_ready, resp0_valid);
        end
        @(posedge clk);
        #1 drive(1, 1'b0, 1'b0, '0, '0);
        ref_mem[1023] = 32'hDEADBEEF;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (resp1_valid !== 1'b1 || resp1_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL bnd_raw got rv=%b rdata=%h exp rv=1 rdata=deadbeef", resp1_valid, resp1_rdata);
        end
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 10'd5, 32'h5555AAAA);
        #1;
        n_checks++;
        if (req1_ready !== 1'b1) begin
            n_fail++; $display("FAIL rb_accept got=%b exp=1", req1_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (mem_writeen !== 1'b1 || mem_addr !== 10'd5) begin
            n_fail++; $display("FAIL rb_busy got we=%b a=%h exp 1 005", mem_writeen, mem_addr);
        end
        #2 reset = 1'b1;
        drive(1, 1'b0, 1'b0, '0, '0);
        #1;
        n_checks++;
        if (mem_writeen !== 1'b0 || mem_addr !== '0 || mem_writeint !== '0) begin
            n_fail++; $display("FAIL rb_mem_drop got=%b/%h/%h exp=0/0/0", mem_writeen, mem_addr, mem_writeint);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (resp1_valid !== 1'b0 || resp0_valid !== 1'b0) begin
            n_fail++; $display("FAIL rb_no_resp got=%b%b exp=00", resp0_valid, resp1_valid);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (resp0_rdata !== '0 || resp1_rdata !== '0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
            mem_writeen !== 1'b0 || mem_addr !== '0 || mem_writeint !== '0) begin
            n_fail++; $display("FAIL rb_after got rd=%h/%h rdy=%b%b mem=%b/%h/%h exp all zero",
                               resp0_rdata, resp1_rdata, req0_ready, req1_ready, mem_writeen, mem_addr, mem_writeint);
        end
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 10'd5, '0);
        drive(1, 1'b1, 1'b0, 10'd6, '0);
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL rb_last_grant got=%b%b exp=10", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (resp0_valid !== 1'b1 || resp0_rdata !== ref_mem[5]) begin
            n_fail++; $display("FAIL rb_old_value got rv=%b rdata=%h exp rv=1 rdata=%h", resp0_valid, resp0_rdata, ref_mem[5]);
        end
    endtask

    task automatic test_random();
        apply_reset();
        run_model(400, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        mem_init = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        test_reset();
        test_write_seq();
        test_read_seq();
        test_contention();
        test_boundary();
        test_reset_busy();
        test_random();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter and access sequencer for the single-port 1024×32 CPU data memory. It shares the memory between the CPU load/store unit (port 0) and the test/loader port (port 1), which preloads the memory before a run and inspects it after. Each port uses a valid/ready request handshake and receives a one-cycle response pulse. The block drives the memory's addr/writeen/writeint inputs and samples its combinational read output RD.

## Interface
Parameters:
- ADDR_W, 10, word address width (1024 words)
- DATA_W, 32, data width

Ports:
- clk  in  1  single clock; all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req0_valid  in  1  port 0 request present
- req0_we  in  1  port 0: 1 = write, 0 = read
- req0_addr  in  ADDR_W  port 0 word address
- req0_wdata  in  DATA_W  port 0 write data
- req0_ready  out  1  port 0 request accepted this cycle
- resp0_valid  out  1  port 0 access complete (1-cycle pulse)
- resp0_rdata  out  DATA_W  port 0 read data, valid with resp0_valid on reads
- req1_* / resp1_*  same set for port 1
- mem_addr  out  ADDR_W  to memory addr
- mem_writeen  out  1  to memory writeen
- mem_writeint  out  DATA_W  to memory writeint
- mem_RD  in  DATA_W  memory combinational read data

## Operation
- FSM states: IDLE, BUSY.
- IDLE: arbitrate among asserted valids; accept at most one request; latch we/addr/wdata and grant id; go to BUSY.
- Arbitration is round-robin on flag last_grant (reset = 1, so port 0 wins the first tie):
  - req0_ready = IDLE & req0_valid & (!req1_valid | last_grant==1)
  - req1_ready = IDLE & req1_valid & (!req0_valid | last_grant==0)
  - ready is combinational from valid; at most one ready high per cycle; last_grant updates to the accepted port on accept.
- BUSY: mem_addr = latched addr; mem_writeint = latched wdata; mem_writeen = latched we. On the closing edge, the memory performs the write (for a write) and mem_RD is captured into the granted port's rdata register (for a read). The FSM then returns to IDLE.
- A response pulse on the granted port follows every access, read or write. On a write, resp_rdata holds its previous value.
- Outside BUSY: mem_writeen = 0, mem_addr = 0, mem_writeint = 0.
- Requester rule: valid, we, addr and wdata must stay stable until ready. A dropped valid before ready is a no-op; nothing is latched.
- The non-granted port's outputs are unaffected by the other port's traffic.

## Timing
- Accept in cycle k (valid & ready high at the edge ending k). BUSY occupies cycle k+1. resp_valid is high for cycle k+2 only, with rdata equal to mem[addr] as of cycle k+1.
- Peak throughput: one access every 2 cycles. ready can be high again in cycle k+2.
- Read after write to the same address from either port returns the new data.
- Simultaneous requests: one is served per 2 cycles, alternating. The loser keeps valid high and is accepted in the next IDLE cycle, i.e. 2 cycles later.
- Address range 0..1023. The address is used as-is, with no wrap or bounds logic.
- Reset values: state = IDLE, last_grant = 1, req*_ready = 0 (while reset is held), resp*_valid = 0, resp*_rdata = 0, mem_writeen = 0, mem_addr = 0, mem_writeint = 0.
- Reset asserted during BUSY:
  - mem_writeen drops immediately, so the pending write is not performed.
  - No response pulse is issued.
  - After release, the FSM starts in IDLE with last_grant = 1.

## Test plan
- Reset, then port 0 writes 49 to addr 0, 7 to addr 1, 2 to addr 2. Each write gives resp0_valid one cycle, 2 cycles after accept. mem_writeen is high exactly one cycle per write.
- Port 1 reads addr 0, 1, 2 -> resp1_rdata = 49, 7, 2, each at accept+2. resp0_valid stays 0.
- Both valid every cycle from reset, reading distinct addresses -> grants alternate 0,1,0,1, one accept every 2 cycles, port 0 first. Neither port waits more than 2 cycles after becoming eligible.
- Port 0 writes 0xDEADBEEF to addr 1023, then port 1 immediately reads 1023 -> port 1 read returns 0xDEADBEEF.
- Port 1 write to addr 5 is accepted, then reset is pulsed in the BUSY cycle -> no resp1_valid and mem[5] unchanged. After release, a read of addr 5 returns the old value and all outputs show reset values.
